cla_seq_adder: RTL and testbench

- Multi-cycle N-byte add/subtract unit built around one shared carry_look_ahead_eight instance.
- An FSM streams the operands through the 8-bit adder one byte per cycle, LSB first, and chains the carry in a register.
- Trades latency for area in wide arithmetic paths.
- Requester-facing interface is a start/busy/done handshake.

---
 rtl/cla_seq_adder.sv | 158 +++++++++++++++
 tb/tb_cla_seq_adder.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/cla_seq_adder.sv
`default_nettype none
// ============================================================================
//  Module   : cla_seq_adder (with helper carry_look_ahead_eight)
//  Purpose  : Multi-cycle N-byte add/subtract unit that streams both
//             operands LSB-first through one shared 8-bit lookahead adder,
//             chaining the carry in a register between bytes.
//  Revision : 1.0 - initial release
// ============================================================================

module carry_look_ahead_eight (
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       cin,
    output logic [7:0] sum,
    output logic       cout
);
    logic [7:0] w_p;
    logic [7:0] w_g;
    logic [8:0] w_c;
    logic       w_term;
    logic       w_prop;

    assign w_p = a ^ b;
    assign w_g = a & b;

    // Every carry is expanded directly from generate/propagate terms and cin,
    // so no carry depends on the carry of the previous bit.
    always_comb begin
        w_c    = '0;
        w_term = 1'b0;
        w_prop = 1'b0;
        w_c[0] = cin;
        for (int i = 0; i < 8; i++) begin
            w_term = w_g[i];
            w_prop = w_p[i];
            for (int j = i - 1; j >= 0; j--) begin
                w_term = w_term | (w_prop & w_g[j]);
                w_prop = w_prop & w_p[j];
            end
            w_c[i+1] = w_term | (w_prop & cin);
        end
    end

    assign sum  = w_p ^ w_c[7:0];
    assign cout = w_c[8];
endmodule

module cla_seq_adder #(
    parameter int NBYTES = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  sub,
    input  logic [8*NBYTES-1:0]   a,
    input  logic [8*NBYTES-1:0]   b,
    output logic                  busy,
    output logic                  done,
    output logic [8*NBYTES-1:0]   sum,
    output logic                  cout,
    output logic                  overflow
);
    localparam int W  = 8 * NBYTES;
    localparam int IW = (NBYTES > 1) ? $clog2(NBYTES) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_next;
    logic [W-1:0]    r_a;
    logic [W-1:0]    r_b;
    logic            r_carry;
    logic [IW-1:0]   r_idx;
    logic            w_accept;
    logic            w_last;
    logic [7:0]      w_byte_sum;
    logic            w_byte_cout;
    logic            w_cin_msb;

    assign w_accept = start && ((r_state == S_IDLE) || (r_state == S_DONE));
    assign w_last   = (r_idx == IW'(NBYTES - 1));

    carry_look_ahead_eight u_cla (
        .a    (r_a[8*r_idx +: 8]),
        .b    (r_b[8*r_idx +: 8]),
        .cin  (r_carry),
        .sum  (w_byte_sum),
        .cout (w_byte_cout)
    );

    // On the last byte the slice MSB is the word MSB, so this is the carry
    // entering bit W-1.
    assign w_cin_msb = r_a[W-1] ^ r_b[W-1] ^ w_byte_sum[7];

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state decode and status outputs.
    always_comb begin
        w_next = r_state;
        busy   = 1'b0;
        done   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) w_next = S_RUN;
            end
            S_RUN: begin
                busy = 1'b1;
                if (w_last) w_next = S_DONE;
            end
            S_DONE: begin
                done   = 1'b1;
                w_next = start ? S_RUN : S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Operand capture, byte-serial accumulation and final flag capture.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a      <= '0;
            r_b      <= '0;
            r_carry  <= 1'b0;
            r_idx    <= '0;
            sum      <= '0;
            cout     <= 1'b0;
            overflow <= 1'b0;
        end else if (w_accept) begin
            // Subtract is A + ~B + 1 with the +1 entering as the carry-in.
            r_a     <= a;
            r_b     <= sub ? ~b : b;
            r_carry <= sub;
            r_idx   <= '0;
            sum     <= '0;
        end else if (r_state == S_RUN) begin
            sum[8*r_idx +: 8] <= w_byte_sum;
            r_carry           <= w_byte_cout;
            r_idx             <= w_last ? '0 : r_idx + 1'b1;
            if (w_last) begin
                cout     <= w_byte_cout;
                overflow <= w_cin_msb ^ w_byte_cout;
            end
        end
    end
endmodule

`default_nettype wire

// File: tb/tb_cla_seq_adder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_cla_seq_adder
//  Purpose  : Self-checking bench for cla_seq_adder (4-byte and 1-byte
//             instances): vector table, handshake latency and corner cases.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_cla_seq_adder;
    logic        clk = 1'b0;
    logic        rst;
    logic        start4, sub4, busy4, done4, cout4, ov4;
    logic [31:0] a4, b4, sum4;
    logic        start1, sub1, busy1, done1, cout1, ov1;
    logic [7:0]  a1, b1, sum1;

    always #5 clk = ~clk;

    cla_seq_adder #(.NBYTES(4)) dut4 (
        .clk(clk), .rst(rst), .start(start4), .sub(sub4), .a(a4), .b(b4),
        .busy(busy4), .done(done4), .sum(sum4), .cout(cout4), .overflow(ov4)
    );

    cla_seq_adder #(.NBYTES(1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .sub(sub1), .a(a1), .b(b1),
        .busy(busy1), .done(done1), .sum(sum1), .cout(cout1), .overflow(ov1)
    );

    typedef struct {
        logic        sub;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] sum;
        logic        cout;
        logic        ov;
    } vec_t;

    typedef struct {
        logic [31:0] sum;
        logic        cout;
        logic        ov;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;

    function automatic void check(string name, logic [31:0] act, logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %h, want %h", name, act, req);
        end
    endfunction

    function automatic logic o_busy(bit w); return w ? busy4 : busy1; endfunction
    function automatic logic o_done(bit w); return w ? done4 : done1; endfunction
    function automatic logic o_cout(bit w); return w ? cout4 : cout1; endfunction
    function automatic logic o_ov(bit w);   return w ? ov4 : ov1;     endfunction
    function automatic logic [31:0] o_sum(bit w);
        return w ? sum4 : {24'h0, sum1};
    endfunction

    function automatic void push(logic [31:0] s, logic c, logic o);
        exp_t e;
        e.sum = s; e.cout = c; e.ov = o;
        sb.push_back(e);
    endfunction

    // Called at a negedge; holds start for one edge, then scrambles the
    // operand inputs to prove the DUT works from its latched copy.
    task automatic drive(bit w, logic s, logic [31:0] a, logic [31:0] b);
        if (w) begin
            start4 = 1'b1; sub4 = s; a4 = a; b4 = b;
        end else begin
            start1 = 1'b1; sub1 = s; a1 = a[7:0]; b1 = b[7:0];
        end
        @(negedge clk);
        start4 = 1'b0; start1 = 1'b0;
        a4 = $urandom(); b4 = $urandom(); sub4 = 1'($urandom());
        a1 = 8'($urandom()); b1 = 8'($urandom()); sub1 = 1'($urandom());
    endtask

    // Counts busy cycles until done, then pops the scoreboard and compares.
    task automatic wait_done(bit w, int lat, string name);
        int   cyc = 0;
        bit   ok  = 1'b0;
        exp_t e;
        for (int k = 0; k < 40; k++) begin
            if (o_done(w)) begin
                ok = 1'b1;
                break;
            end
            if (o_busy(w)) cyc++;
            @(negedge clk);
        end
        check($sformatf("%s.done_seen", name), 32'(ok), 32'd1);
        check($sformatf("%s.busy_cycles", name), 32'(cyc), 32'(lat));
        check($sformatf("%s.busy_at_done", name), 32'(o_busy(w)), 32'd0);
        if (sb.size() == 0) begin
            n_vec++; n_err++;
            $display("FAIL %s.scoreboard: got empty queue, want an entry", name);
        end else begin
            e = sb.pop_front();
            check($sformatf("%s.sum", name),  o_sum(w),         e.sum);
            check($sformatf("%s.cout", name), 32'(o_cout(w)),   32'(e.cout));
            check($sformatf("%s.ovf", name),  32'(o_ov(w)),     32'(e.ov));
        end
    endtask

    vec_t tv4[8];
    vec_t tv1[3];

    initial begin
        tv4[0] = '{1'b0, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b1, 1'b0};
        tv4[1] = '{1'b0, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b0, 1'b1};
        tv4[2] = '{1'b0, 32'h12345678, 32'h9ABCDEF0, 32'hACF13568, 1'b0, 1'b0};
        tv4[3] = '{1'b1, 32'h00000005, 32'h00000007, 32'hFFFFFFFE, 1'b0, 1'b0};
        tv4[4] = '{1'b1, 32'h80000000, 32'h00000001, 32'h7FFFFFFF, 1'b1, 1'b1};
        tv4[5] = '{1'b1, 32'h00001234, 32'h00001234, 32'h00000000, 1'b1, 1'b0};
        tv4[6] = '{1'b1, 32'h00000000, 32'h80000000, 32'h80000000, 1'b0, 1'b1};
        tv4[7] = '{1'b0, 32'h80000000, 32'h80000000, 32'h00000000, 1'b1, 1'b1};
        tv1[0] = '{1'b0, 32'h80, 32'h80, 32'h00, 1'b1, 1'b1};
        tv1[1] = '{1'b0, 32'h7F, 32'h01, 32'h80, 1'b0, 1'b1};
        tv1[2] = '{1'b1, 32'h00, 32'h01, 32'hFF, 1'b0, 1'b0};

        rst = 1'b1;
        start4 = 1'b0; sub4 = 1'b0; a4 = '0; b4 = '0;
        start1 = 1'b0; sub1 = 1'b0; a1 = '0; b1 = '0;
        repeat (2) @(negedge clk);
        check("reset.busy4", 32'(busy4), 32'd0);
        check("reset.done4", 32'(done4), 32'd0);
        check("reset.sum4",  sum4,       32'd0);
        check("reset.cout4", 32'(cout4), 32'd0);
        check("reset.ovf4",  32'(ov4),   32'd0);
        check("reset.busy1", 32'(busy1), 32'd0);
        check("reset.sum1",  32'(sum1),  32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Table-driven 4-byte operations, each followed by a hold check.
        for (int i = 0; i < 8; i++) begin
            push(tv4[i].sum, tv4[i].cout, tv4[i].ov);
            drive(1'b1, tv4[i].sub, tv4[i].a, tv4[i].b);
            wait_done(1'b1, 4, $sformatf("v4[%0d]", i));
            @(negedge clk);
            check($sformatf("v4[%0d].done_pulse", i), 32'(done4), 32'd0);
            check($sformatf("v4[%0d].sum_hold", i),   sum4,       tv4[i].sum);
        end

        // Reset mid-RUN: cout/overflow are 1 from the last table vector.
        drive(1'b1, 1'b0, 32'hFFFFFFFF, 32'h00000001);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("midrst.busy", 32'(busy4), 32'd0);
        check("midrst.done", 32'(done4), 32'd0);
        check("midrst.sum",  sum4,       32'd0);
        check("midrst.cout", 32'(cout4), 32'd0);
        check("midrst.ovf",  32'(ov4),   32'd0);
        @(negedge clk);
        rst = 1'b0;
        begin
            bit seen = 1'b0;
            for (int k = 0; k < 8; k++) begin
                @(negedge clk);
                if (done4 || busy4) seen = 1'b1;
            end
            check("midrst.no_activity", 32'(seen), 32'd0);
        end
        push(32'd7, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 32'd3, 32'd4);
        wait_done(1'b1, 4, "post_rst");
        @(negedge clk);

        // Start during RUN is ignored; start in DONE is taken back-to-back.
        push(32'd3, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 32'd1, 32'd2);
        @(negedge clk);
        start4 = 1'b1; sub4 = 1'b0; a4 = 32'd9; b4 = 32'd9;
        @(negedge clk);
        start4 = 1'b0;
        wait_done(1'b1, 2, "ignored_start");
        push(32'd8, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 32'd4, 32'd4);
        check("b2b.busy_no_gap", 32'(busy4), 32'd1);
        wait_done(1'b1, 4, "b2b");
        @(negedge clk);

        // Single-byte instance.
        for (int i = 0; i < 3; i++) begin
            push(tv1[i].sum, tv1[i].cout, tv1[i].ov);
            drive(1'b0, tv1[i].sub, tv1[i].a, tv1[i].b);
            wait_done(1'b0, 1, $sformatf("v1[%0d]", i));
            @(negedge clk);
            check($sformatf("v1[%0d].done_pulse", i), 32'(done1), 32'd0);
        end

        check("scoreboard.empty", 32'(sb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish, want finish before 200000");
        $fatal(1);
    end
endmodule
`default_nettype wire
